// File: rtl/riscv_crypto_aes_subword_seq.sv
// Iterative AES SubWord with optional RotWord: NSBOX shared forward/inverse S-box lanes per cycle.
// Optional macro RISCV_CRYPTO_SUBWORD_BACK2BACK_EN allows a new request to be accepted from HOLD.
module riscv_crypto_aes_subword_seq #(
    parameter int XLEN  = 32,
    parameter int NSBOX = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_dec,
    input  logic            in_rot,
    input  logic [XLEN-1:0] in_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_word,
    output logic            busy
);
    localparam int BYTES = XLEN / 8;
    localparam int NCYC  = BYTES / NSBOX;
    localparam int CW    = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [XLEN-1:0] word_reg;
    logic [XLEN-1:0] res_reg;
    logic [XLEN-1:0] res_next;
    logic            dec_reg;
    logic            rot_reg;
    logic            accept;
    logic [7:0]      lane_in  [NSBOX];
    logic [7:0]      lane_out [NSBOX];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    // One field inverter shared by both directions; only the affine stage moves.
    function automatic logic [7:0] sbox(input logic [7:0] x, input logic dec);
        logic [7:0] y;
        y = gf_inv(dec ? inv_affine(x) : x);
        return dec ? y : fwd_affine(y);
    endfunction

    function automatic logic [XLEN-1:0] rot_word(input logic [XLEN-1:0] w);
        logic [XLEN-1:0] r;
        r = '0;
        for (int h = 0; h < XLEN / 32; h++) begin
            r[h*32 +: 32] = {w[h*32 +: 24], w[h*32+24 +: 8]};
        end
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < NSBOX; gi++) begin : g_lane
            assign lane_in[gi]  = word_reg[(int'(cnt_reg) * NSBOX + gi) * 8 +: 8];
            assign lane_out[gi] = sbox(lane_in[gi], dec_reg);
        end
    endgenerate

    always_comb begin
        res_next = res_reg;
        for (int i = 0; i < NSBOX; i++) begin
            res_next[(int'(cnt_reg) * NSBOX + i) * 8 +: 8] = lane_out[i];
        end
    end

`ifdef RISCV_CRYPTO_SUBWORD_BACK2BACK_EN
    assign in_ready = !flush && ((state_reg == IDLE) || ((state_reg == HOLD) && out_ready));
`else
    assign in_ready = !flush && (state_reg == IDLE);
`endif

    assign accept = in_valid && in_ready;
    assign busy   = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            word_reg  <= '0;
            res_reg   <= '0;
            dec_reg   <= 1'b0;
            rot_reg   <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= '0;
        end else if (flush) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        word_reg  <= in_word;
                        dec_reg   <= in_dec;
                        rot_reg   <= in_rot;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    res_reg <= res_next;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= HOLD;
                        out_valid <= 1'b1;
                        out_word  <= rot_reg ? rot_word(res_next) : res_next;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                        // accept can only be high here in back-to-back builds
                        if (accept) begin
                            word_reg  <= in_word;
                            dec_reg   <= in_dec;
                            rot_reg   <= in_rot;
                            cnt_reg   <= '0;
                            state_reg <= RUN;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_crypto_aes_subword_seq.sv
// Bench for riscv_crypto_aes_subword_seq: directed 32-bit/1-lane vectors plus a 64-bit/8-lane stream.
module tb_riscv_crypto_aes_subword_seq;
    logic clk;
    logic rst;

    logic        a_flush, a_in_valid, a_in_ready, a_in_dec, a_in_rot;
    logic [31:0] a_in_word, a_out_word;
    logic        a_out_valid, a_out_ready, a_busy;

    logic        b_flush, b_in_valid, b_in_ready, b_in_dec, b_in_rot;
    logic [63:0] b_in_word, b_out_word;
    logic        b_out_valid, b_out_ready, b_busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    riscv_crypto_aes_subword_seq #(.XLEN(32), .NSBOX(1)) u_dut32 (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_dec(a_in_dec), .in_rot(a_in_rot),
        .in_word(a_in_word), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_word(a_out_word), .busy(a_busy)
    );

    riscv_crypto_aes_subword_seq #(.XLEN(64), .NSBOX(8)) u_dut64 (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_dec(b_in_dec), .in_rot(b_in_rot),
        .in_word(b_in_word), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_word(b_out_word), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference S-box built from exp/log tables over generator 0x03.
    task automatic build_tables();
        logic [7:0] e, b, s, c;
        logic [7:0] ex [256];
        int lg [256];
        e = 8'h01;
        for (int i = 0; i < 256; i++) lg[i] = 0;
        for (int i = 0; i < 255; i++) begin
            ex[i] = e;
            lg[e] = i;
            e = e ^ {e[6:0], 1'b0} ^ (e[7] ? 8'h1b : 8'h00);
        end
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            b = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
            for (int i = 0; i < 8; i++) begin
                s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
            end
            fwd_t[x] = s;
            inv_t[s] = 8'(x);
        end
    endtask

    function automatic logic [63:0] sub64(input logic [63:0] w, input logic d, input logic r);
        logic [63:0] o;
        for (int i = 0; i < 8; i++) o[i*8 +: 8] = d ? inv_t[w[i*8 +: 8]] : fwd_t[w[i*8 +: 8]];
        if (r) o = {o[55:32], o[63:56], o[23:0], o[31:24]};
        return o;
    endfunction

    // Called at posedge+1; leaves at posedge+1 after the result has been consumed.
    task automatic run32(input string tag, input logic [31:0] w, input logic dec,
                         input logic rot, input logic [31:0] exp);
        int cyc;
        a_in_word = w; a_in_dec = dec; a_in_rot = rot; a_in_valid = 1'b1;
        #1;
        check({tag, "_rdy"}, a_in_ready, 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_word = ~w; a_in_dec = ~dec; a_in_rot = ~rot;
        cyc = 0;
        while (!a_out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, 4);
        check({tag, "_word"}, a_out_word, exp);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        $display("txn %s: in=0x%08h dec=%0d rot=%0d out=0x%08h", tag, w, dec, rot, exp);
        check({tag, "_done"}, a_out_valid, 0);
    endtask

    task automatic stream64();
        logic [63:0] exp_q [$];
        logic [63:0] w, e;
        logic d, r;
        int idx, recv, cyc;
        idx = 0; recv = 0; cyc = 0;
        w = {$urandom, $urandom}; d = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
        while (recv < 16 && cyc < 3000) begin
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_in_valid  = (idx < 16);
            b_in_word = w; b_in_dec = d; b_in_rot = r;
            #1;
`ifdef RISCV_CRYPTO_SUBWORD_BACK2BACK_EN
            if (b_out_valid && b_out_ready) check("s_b2b_rdy", b_in_ready, 1);
`else
            if (b_out_valid) check("s_hold_rdy", b_in_ready, 0);
`endif
            if (b_out_valid && b_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("s_extra", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn s%0d: out=0x%016h exp=0x%016h", recv, b_out_word, e);
                    check("s_word", b_out_word, e);
                    recv++;
                end
            end
            if (b_in_valid && b_in_ready) begin
                exp_q.push_back(sub64(w, d, r));
                idx++;
                w = {$urandom, $urandom}; d = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("s_recv", recv, 16);
        check("s_left", exp_q.size(), 0);
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("s_nodup", b_out_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_flush = 0; a_in_valid = 0; a_in_dec = 0; a_in_rot = 0; a_in_word = '0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_dec = 0; b_in_rot = 0; b_in_word = '0; b_out_ready = 0;
        build_tables();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", a_out_valid, 0);
        check("rst_word", a_out_word, 0);
        check("rst_busy", a_busy, 0);
        check("rst_rdy", a_in_ready, 1);
        check("rst_b_valid", b_out_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run32("fwd0", 32'h00000000, 1'b0, 1'b0, 32'h63636363);
        run32("fwdrot", 32'h09cf4f3c, 1'b0, 1'b1, 32'h8a84eb01);
        run32("inv63", 32'h63636363, 1'b1, 1'b0, 32'h00000000);
        run32("invmix", 32'h00ed0053, 1'b1, 1'b0, 32'h52535250);
        run32("fwd_mix", 32'h01020304, 1'b0, 1'b0, 32'h7c777bf2);

        // Consumer stall: result must hold steady and no new request is taken.
        a_in_word = 32'h00000000; a_in_dec = 0; a_in_rot = 0; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a_in_valid = 1'b1; a_in_word = 32'h11111111;
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", a_out_valid, 1);
            check("hold_word", a_out_word, 32'h63636363);
            check("hold_rdy", a_in_ready, 0);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        $display("txn hold: out=0x63636363 released after 10 stall cycles");
        for (int i = 0; i < 5; i++) begin
            check("hold_once", a_out_valid, 0);
            @(posedge clk); #1;
        end

        // Flush in the second RUN cycle.
        a_in_word = 32'h11223344; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        a_flush = 1'b1;
        #1;
        check("flush_rdy", a_in_ready, 0);
        @(posedge clk); #1;
        a_flush = 1'b0;
        check("flush_busy", a_busy, 0);
        check("flush_valid", a_out_valid, 0);
        a_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("flush_novalid", a_out_valid, 0);
        end
        a_out_ready = 1'b0;
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_word = 32'h53535353;
        #1;
        check("flush_idle_rdy", a_in_ready, 0);
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("flush_noacc", a_busy, 0);
        $display("txn flush: word 0x11223344 dropped");
        run32("postflush", 32'h53535353, 1'b0, 1'b0, 32'hedededed);

        // Asynchronous reset mid-RUN.
        a_in_word = 32'h01020304; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_valid", a_out_valid, 0);
        check("arst_word", a_out_word, 0);
        check("arst_busy", a_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("arst_rdy", a_in_ready, 1);
        @(posedge clk); #1;
        check("arst_idle", a_busy, 0);
        $display("txn arst: word 0x01020304 lost to reset");
        run32("postrst", 32'hedededed, 1'b1, 1'b1, 32'h53535353);

        stream64();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
